// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage and the difftest wrapper: the commit-record
// layout and the sizing helpers used by the stage.
package mem_wb_stage_pkg;

    localparam int DIFF_DELAY_MAX = 8;

    // Commit record, MSB first: {valid, pc, rd_ena, rd_addr, rd_data}.
    // The difftest wrapper must unpack with these same offsets.
    function automatic int commit_rec_w(input int xlen, input int pc_w, input int reg_aw);
        return 1 + pc_w + 1 + reg_aw + xlen;
    endfunction

    function automatic int rec_addr_lsb(input int xlen);
        return xlen;
    endfunction

    function automatic int rec_ena_bit(input int xlen, input int reg_aw);
        return xlen + reg_aw;
    endfunction

    function automatic int rec_pc_lsb(input int xlen, input int reg_aw);
        return xlen + reg_aw + 1;
    endfunction

    function automatic int rec_valid_bit(input int xlen, input int pc_w, input int reg_aw);
        return xlen + reg_aw + 1 + pc_w;
    endfunction

    function automatic int idle_cnt_w(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM-stage to WB-stage instruction bundle with its ready back-pressure.
interface mem_wb_stage_if #(
    parameter int XLEN   = 64,
    parameter int PC_W   = 64,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic [PC_W-1:0]   in_pc;
    logic [XLEN-1:0]   in_rd_data;
    logic [REG_AW-1:0] in_rd_addr;
    logic              in_rd_ena;
    logic              in_ready;

    modport master (
        output in_valid, in_pc, in_rd_data, in_rd_addr, in_rd_ena,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_pc, in_rd_data, in_rd_addr, in_rd_ena,
        output in_ready
    );
endinterface

// File: rtl/mem_wb_stage_commit_delay_line.sv
// Fixed-depth shift register for commit records; a plain wire when DEPTH is 0.
module commit_delay_line #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign q = d;
    end else begin : g_shift
        logic [W-1:0] stage_reg [DEPTH];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
            end else begin
                stage_reg[0] <= d;
                for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
            end
        end

        assign q = stage_reg[DEPTH-1];
    end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with stall/flush, a delayed commit trace for difftest,
// a retired-instruction counter and a sticky no-commit watchdog.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int PC_W       = 64,
    parameter int REG_AW     = 5,
    parameter int DIFF_DELAY = 2,
    parameter int CNT_W      = 64,
    parameter int TIMEOUT    = 5000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    mem_wb_stage_if.slave     in_bus,
    output logic              wb_valid,
    output logic [PC_W-1:0]   wb_pc,
    output logic [XLEN-1:0]   wb_rd_data,
    output logic [REG_AW-1:0] wb_rd_addr,
    output logic              wb_rd_ena,
    output logic              commit_valid,
    output logic [PC_W-1:0]   commit_pc,
    output logic              commit_rd_ena,
    output logic [REG_AW-1:0] commit_rd_addr,
    output logic [XLEN-1:0]   commit_rd_data,
    output logic [CNT_W-1:0]  commit_cnt,
    output logic              commit_timeout
);
    localparam int REC_W     = commit_rec_w(XLEN, PC_W, REG_AW);
    localparam int ADDR_LSB  = rec_addr_lsb(XLEN);
    localparam int ENA_BIT   = rec_ena_bit(XLEN, REG_AW);
    localparam int PC_LSB    = rec_pc_lsb(XLEN, REG_AW);
    localparam int VALID_BIT = rec_valid_bit(XLEN, PC_W, REG_AW);
    localparam int IDLE_W    = idle_cnt_w(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

    if (DIFF_DELAY < 0 || DIFF_DELAY > DIFF_DELAY_MAX) begin : g_bad_delay
        $error("mem_wb_stage: DIFF_DELAY must be within 0..%0d", DIFF_DELAY_MAX);
    end

    logic              wb_new_reg;
    logic [REC_W-1:0]  rec_in;
    logic [REC_W-1:0]  rec_out;
    logic [IDLE_W-1:0] idle_reg;
    logic [IDLE_W-1:0] idle_next;

    assign in_bus.in_ready = !stall;

    // Flush shares the reset path so it wins over a simultaneous stall.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wb_valid   <= 1'b0;
            wb_pc      <= '0;
            wb_rd_data <= '0;
            wb_rd_addr <= '0;
            wb_rd_ena  <= 1'b0;
            wb_new_reg <= 1'b0;
        end else if (stall) begin
            wb_new_reg <= 1'b0;
        end else begin
            wb_valid   <= in_bus.in_valid;
            wb_pc      <= in_bus.in_pc;
            wb_rd_data <= in_bus.in_rd_data;
            wb_rd_addr <= in_bus.in_rd_addr;
            wb_rd_ena  <= in_bus.in_valid & in_bus.in_rd_ena & (in_bus.in_rd_addr != '0);
            wb_new_reg <= in_bus.in_valid;
        end
    end

    // wb_new gates the record so a stalled instruction enters the line only once.
    assign rec_in = {wb_valid & wb_new_reg, wb_pc, wb_rd_ena, wb_rd_addr, wb_rd_data};

    commit_delay_line #(
        .DEPTH (DIFF_DELAY),
        .W     (REC_W)
    ) u_commit_delay_line (
        .clk (clk),
        .rst (rst),
        .d   (rec_in),
        .q   (rec_out)
    );

    assign commit_valid   = rec_out[VALID_BIT];
    assign commit_pc      = rec_out[PC_LSB +: PC_W];
    assign commit_rd_ena  = rec_out[ENA_BIT];
    assign commit_rd_addr = rec_out[ADDR_LSB +: REG_AW];
    assign commit_rd_data = rec_out[0 +: XLEN];

    always_comb begin
        idle_next = idle_reg;
        if (commit_valid) begin
            idle_next = '0;
        end else if (idle_reg != IDLE_MAX) begin
            idle_next = idle_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            commit_cnt     <= '0;
            idle_reg       <= '0;
            commit_timeout <= 1'b0;
        end else begin
            commit_cnt     <= commit_cnt + CNT_W'(commit_valid);
            idle_reg       <= idle_next;
            commit_timeout <= commit_timeout | (idle_next == IDLE_MAX);
        end
    end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Parametrised MEM/WB pipeline register with explicit valid bit, stall hold, and flush bubble.
- Produces a configurable-depth delayed commit trace (pc, rd write info) for the difftest wrapper, plus a retired-instruction counter and a commit-timeout watchdog.
- Sits between the MEM stage and the regfile write port; the commit outputs feed the difftest DPI wrapper, which is a separate block.

Parameters:
- XLEN, 64, width of rd data.
- PC_W, 64, width of the PC.
- REG_AW, 5, register address width.
- DIFF_DELAY, 2, commit-trace delay in cycles, legal range 0..8.
- CNT_W, 64, width of the commit counter.
- TIMEOUT, 5000, number of cycles without a commit before commit_timeout sets.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold the WB register (from stall controller).
- flush  in  1  load a bubble into the WB register.
- in_valid  in  1  MEM stage holds a real instruction.
- in_pc  in  PC_W  PC of the MEM-stage instruction.
- in_rd_data  in  XLEN  rd write data.
- in_rd_addr  in  REG_AW  rd address.
- in_rd_ena  in  1  rd write request.
- in_ready  out  1  combinational; equals !stall.
- wb_valid  out  1  WB register holds an instruction.
- wb_pc  out  PC_W  PC of the WB instruction.
- wb_rd_data  out  XLEN  regfile write data.
- wb_rd_addr  out  REG_AW  regfile write address.
- wb_rd_ena  out  1  regfile write enable.
- commit_valid  out  1  one-cycle commit pulse for difftest.
- commit_pc  out  PC_W  PC of the committed instruction.
- commit_rd_ena  out  1  rd write enable of the committed instruction.
- commit_rd_addr  out  REG_AW  rd address of the committed instruction.
- commit_rd_data  out  XLEN  rd data of the committed instruction.
- commit_cnt  out  CNT_W  retired-instruction count.
- commit_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset: all registered outputs are 0, including the wb_new flag, every delay-line stage, commit_cnt, the idle counter and commit_timeout.
- WB register update priority: rst > flush > stall > load.
  - flush: wb_valid, wb_rd_ena, wb_rd_addr, wb_rd_data and wb_pc all become 0. Flush wins over a simultaneous stall.
  - stall (no flush): every WB field holds, including wb_pc.
  - load: capture all inputs. wb_valid = in_valid. wb_rd_ena = in_valid & in_rd_ena & (in_rd_addr != 0), so writes to x0 are suppressed.
- wb_new flag: set to in_valid on a load cycle; cleared on any stall or flush cycle.
- Delay-line input: {wb_valid & wb_new, wb_pc, wb_rd_ena, wb_rd_addr, wb_rd_data}. The line shifts every cycle and is never frozen by stall.
  - An instruction therefore commits exactly once, however long it is stalled in WB.
- Commit latency:
  - Instruction loaded at edge N (visible in WB in cycle N): commit_valid is high in cycle N+DIFF_DELAY for exactly one cycle.
  - DIFF_DELAY = 0: commit outputs are combinational from the WB register gated by wb_new.
- Once wb_valid & wb_new enters the line, it propagates unconditionally. A later flush does not cancel a commit already in flight; rst does clear it.
- commit_cnt: increments by 1 on each commit_valid cycle and wraps modulo 2^CNT_W.
- Idle counter (width ceil(log2(TIMEOUT+1))):
  - Clears on commit_valid; otherwise increments, saturating at TIMEOUT.
  - commit_timeout sets when the counter reaches TIMEOUT and stays set until rst.
- Elaboration check: DIFF_DELAY outside 0..8 is an error.

Decomposition:
- Width macros (REGBUS, PCBUS, REGADDRBUS, ZEROWORD, STOP/NOSTOP) come from the shared defines include.
- Add a shared commit-record field-order definition there, so the difftest wrapper agrees with this block.
- One natural sub-module: commit_delay_line. Parameters DEPTH and W; a plain shift register with synchronous reset that is a wire-through when DEPTH = 0.

Test Plan:
- Basic flow: load pc=0x80000000, rd=x5, data=0x1234, in_valid=1, in_rd_ena=1 at edge N -> WB fields match in cycle N; commit_valid pulses in cycle N+2 with the same values; commit_cnt goes 0 -> 1.
- x0 suppression: in_rd_addr=0, in_rd_ena=1 -> wb_rd_ena=0; the instruction still commits with commit_rd_ena=0.
- Stall hold: load pc=0x80000004, then assert stall for 5 cycles -> WB fields (including wb_pc) hold; in_ready=0 throughout; exactly one commit_valid pulse; commit_cnt increments by 1.
- Flush priority: flush=1 and stall=1 in the same cycle with valid WB contents -> next cycle wb_valid=0, wb_pc=0, wb_rd_ena=0; an instruction loaded the previous cycle still commits 2 cycles after its load.
- Reset mid-flight: rst asserted in the cycle after a load -> no commit_valid ever appears for that instruction; all outputs read 0 in the following cycle.
- Watchdog and delay sweep: TIMEOUT=10, no valid input for 10 cycles -> commit_timeout=1 and sticky through later commits. Repeat the basic-flow case for DIFF_DELAY = 0, 1 and 8 -> commit latency equals DIFF_DELAY.
